// File: rtl/dmem_access_ctrl_if.sv
// Bundles the pipeline request/response handshake and the data-memory bus
// of dmem_access_ctrl; master is the controller side, slave the environment.
interface dmem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  busy;
    logic                  resp_valid;
    logic                  resp_we;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, busy, resp_valid, resp_we, resp_rdata, resp_err,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, busy, resp_valid, resp_we, resp_rdata, resp_err,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one load/store at a time, registered outputs.
// Optional WAIT-state timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ADDR_SHIFT     = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    dmem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    logic                  we_r;
    logic                  req_ready_r;
    logic                  busy_r;
    logic                  resp_valid_r;
    logic                  resp_we_r;
    logic [DATA_WIDTH-1:0] resp_rdata_r;
    logic                  resp_err_r;
    logic                  mem_rd_en_r;
    logic                  mem_wr_en_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_r;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^32'(TIMEOUT_CYCLES);
`endif

    // Access sequencer: all outputs are produced here so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_we_r    <= 1'b0;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
            mem_rd_en_r  <= 1'b0;
            mem_wr_en_r  <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_r    <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_r        <= bus.req_we;
                        mem_addr_r  <= bus.req_addr >> ADDR_SHIFT;
                        mem_wdata_r <= bus.req_wdata;
                        mem_wr_en_r <= bus.req_we;
                        mem_rd_en_r <= ~bus.req_we;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
`ifdef DMEM_TIMEOUT_EN
                        tmo_cnt_r   <= {CNT_W{1'b0}};
`endif
                    end else begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                // mem_ready is not sampled here: the memory holds it low under the strobe.
                ST_ISSUE: begin
                    mem_rd_en_r <= 1'b0;
                    mem_wr_en_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        if (!we_r) begin
                            resp_rdata_r <= bus.mem_rdata;
                        end else begin
                            resp_rdata_r <= resp_rdata_r;
                        end
                        resp_valid_r <= 1'b1;
                        resp_we_r    <= we_r;
                        resp_err_r   <= 1'b0;
                        state_r      <= ST_RESP;
`ifdef DMEM_TIMEOUT_EN
                    end else if (tmo_cnt_r == CNT_LAST) begin
                        resp_rdata_r <= {DATA_WIDTH{1'b0}};
                        resp_valid_r <= 1'b1;
                        resp_we_r    <= we_r;
                        resp_err_r   <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        tmo_cnt_r    <= tmo_cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r      <= ST_WAIT;
`endif
                    end
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_we_r    <= 1'b0;
                    resp_err_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    mem_rd_en_r  <= 1'b0;
                    mem_wr_en_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.busy       = busy_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_we    = resp_we_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_rd_en  = mem_rd_en_r;
    assign bus.mem_wr_en  = mem_wr_en_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: the bench plays both the pipeline and
// a variable-latency memory, and predicts every cycle from a transaction model.
module tb_dmem_access_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SH  = 0;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;

    dmem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_access_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .ADDR_SHIFT    (SH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [DW-1:0] last_rdata;

    // Unwritten locations read back their own address.
    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        else return DW'(a);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access: pipeline request, memory response after lat cycles.
    task automatic do_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int lat,
                             input bit stuck, input bit hold);
        logic [AW-1:0] maddr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        maddr         = addr >> SH;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        check_eq("req_ready_idle", bus.req_ready, 1'b1);
        step();
        if (!hold) bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        check_eq("strobe_wr", bus.mem_wr_en, we);
        check_eq("strobe_rd", bus.mem_rd_en, !we);
        check_eq("mem_addr", bus.mem_addr, maddr);
        if (we) check_eq("mem_wdata", bus.mem_wdata, wdata);
        check_eq("busy_issue", bus.busy, 1'b1);
        check_eq("req_ready_issue", bus.req_ready, 1'b0);
        if (we) mem_model[maddr] = wdata;
        for (int k = 1; k <= lat; k++) begin
            step();
            check_eq("strobe_off", {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
            check_eq("mem_addr_hold", bus.mem_addr, maddr);
            check_eq("resp_early", bus.resp_valid, 1'b0);
            check_eq("busy_wait", bus.busy, 1'b1);
            check_eq("req_ready_wait", bus.req_ready, 1'b0);
            if (k == lat && !stuck) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = we ? DW'($urandom) : mem_read(maddr);
            end
        end
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DW'($urandom);
        if (stuck) begin
            exp_rdata = {DW{1'b0}};
            exp_err   = 1'b1;
        end else begin
            exp_rdata = we ? last_rdata : mem_read(maddr);
            exp_err   = 1'b0;
        end
        check_eq("resp_valid", bus.resp_valid, 1'b1);
        check_eq("resp_we", bus.resp_we, we);
        check_eq("resp_rdata", bus.resp_rdata, exp_rdata);
        check_eq("resp_err", bus.resp_err, exp_err);
        check_eq("busy_resp", bus.busy, 1'b1);
        last_rdata = exp_rdata;
        step();
        check_eq("resp_pulse_end", bus.resp_valid, 1'b0);
        check_eq("busy_done", bus.busy, 1'b0);
        check_eq("req_ready_done", bus.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = {AW{1'b0}};
        bus.req_wdata = {DW{1'b0}};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {DW{1'b0}};
        last_rdata    = {DW{1'b0}};
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", bus.req_ready, 1'b1);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
        check_eq("rst_mem_addr", bus.mem_addr, {AW{1'b0}});
        check_eq("rst_mem_wdata", bus.mem_wdata, {DW{1'b0}});
        check_eq("rst_resp", {bus.resp_valid, bus.resp_we, bus.resp_err}, 3'b000);
        check_eq("rst_resp_rdata", bus.resp_rdata, {DW{1'b0}});
        reset = 1'b0;

        // Idle with memory ready toggling: nothing may happen.
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            step();
            check_eq("idle_req_ready", bus.req_ready, 1'b1);
            check_eq("idle_busy", bus.busy, 1'b0);
            check_eq("idle_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
            check_eq("idle_resp", bus.resp_valid, 1'b0);
        end
        bus.mem_ready = 1'b1;

        do_access(1'b0, 32'h0000_0010, 32'h0, 4, 1'b0, 1'b0);
        do_access(1'b1, 32'h0000_0005, 32'hCAFE_F00D, 3, 1'b0, 1'b0);
        do_access(1'b0, 32'h0000_0005, 32'h0, 2, 1'b0, 1'b0);

        // Three requests with req_valid held high throughout.
        do_access(1'b1, 32'h0000_0007, 32'h1234_5678, 1, 1'b0, 1'b1);
        do_access(1'b0, 32'h0000_0007, 32'h0, 2, 1'b0, 1'b1);
        do_access(1'b0, 32'h0000_0009, 32'h0, 5, 1'b0, 1'b0);

        // Reset while waiting on memory.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0020;
        step();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("rstw_busy", bus.busy, 1'b0);
        check_eq("rstw_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
        check_eq("rstw_resp", bus.resp_valid, 1'b0);
        check_eq("rstw_req_ready", bus.req_ready, 1'b1);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        last_rdata    = {DW{1'b0}};
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rstw_no_resp", bus.resp_valid, 1'b0);
        end
        do_access(1'b0, 32'h0000_0020, 32'h0, 3, 1'b0, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        do_access(1'b0, 32'h0000_0040, 32'h0, TMO, 1'b1, 1'b0);
        do_access(1'b0, 32'h0000_0005, 32'h0, 2, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            do_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                      DW'($urandom), $urandom_range(1, 6), 1'b0,
                      1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
